systolic_row_feeder: RTL
========================

Name: systolic_row_feeder

Overview:
- Upstream driver for one systolic PE row of M MAC cells. Accepts a stream of operand beats, where each beat is one A value plus M B values.
- Drives the row's A input and its M column B inputs with the diagonal skew the row needs: column j is delayed j cycles to match A's j-stage register ripple.
- Sequences the per-PE clr/read/write control vectors: hold clear while idle, MAC during the stream, then a staggered write (unload) per column.
- Flags the cycle on which each column's result is valid on that column's B output.

Parameters:
- N, 32, operand/accumulator width.
- M, 5, number of PEs (columns) in the row.
- CW, 8, width of the beat counter (max beats per job = 2^CW-1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  beat offered.
- in_ready  output  1  feeder can take a beat.
- in_last  input  1  offered beat is the final beat of the job.
- in_a  input  N  A operand of the beat.
- in_b  input  M*N  B operands; column j occupies bits [j*N +: N].
- a_out  output  N  to the row's A input.
- b_out  output  M*N  to the row's B inputs, skewed per column.
- clr  output  M  per-PE clear.
- read  output  M  per-PE load; driven constant 0 by this block.
- write  output  M  per-PE unload (Bout<=Acc).
- res_valid  output  M  bit j high means column j's B output carries its accumulator this cycle.
- busy  output  1  high in STREAM and DRAIN.
- beat_count  output  CW  beats accepted in the current or last job.

Behaviour:
- All outputs are registered. Reset gives: state IDLE, clr = all ones, and a_out, b_out, write, read, res_valid, busy, beat_count all 0. All skew delay lines are reset to 0.
- IDLE:
  - in_ready=1, clr=all ones, data outputs 0.
  - An accepted beat (in_valid&in_ready) in cycle c sets a_out=in_a and clr=0 in cycle c+1.
  - beat_count is cleared to 0, then 1 is counted for this beat.
  - Next state is STREAM, or DRAIN if in_last is set on that beat.
- STREAM:
  - in_ready=1 and clr=write=0, so every PE MACs.
  - Each cycle the front of the pipe takes the accepted beat. With no beat offered, it takes a zero bubble (a=0, b=0); bubbles add 0 and keep the skew intact.
  - beat_count increments per accepted beat and saturates at 2^CW-1.
  - The beat accepted with in_last moves the state to DRAIN.
- Skew: b_out column j in cycle t equals the B[j] of the beat (or bubble) presented on a_out in cycle t-j. Column 0 has no delay. Delay lines shift every cycle in STREAM and DRAIN.
- DRAIN:
  - in_ready=0; zeros enter the pipe front.
  - Let tL be the cycle in which a_out carries the last beat.
  - write[j]=1 only in cycle tL+1+j.
  - clr[j]=1 from cycle tL+2+j onward; this protects the result from being overwritten by bubbles.
  - res_valid[j]=1 only in cycle tL+2+j.
  - In cycle tL+M+1, res_valid[M-1] fires and the state returns to IDLE. All clr bits are 1 from the next cycle.
- Per column, write and clr are never both high, and read stays 0. Together these keep every PE out of its ambiguous control encodings.
- busy is high from c+1 of the first beat through tL+M+1.
- Width rules: no arithmetic is done on the data path; operands pass through unchanged. beat_count saturates and does not wrap.
- Reset mid-job: the pipe is flushed immediately, with clr=all ones and no write or res_valid pulse.
- Single-beat job (in_last on the first beat): IDLE goes straight to DRAIN, with tL = c+1.

Test Plan:
- Reset, then idle 5 cycles -> clr=5'b11111, in_ready=1, busy=0, all data 0.
- 3 back-to-back beats (a=1,2,3; b[j]=j+1 per beat), last on beat 3 -> b_out[4] shows 5,5,5 in cycles c+5..c+7; write[j] at tL+1+j; res_valid[4] at tL+6; then IDLE.
- Same job with in_valid low for 2 cycles between beats 1 and 2 -> two zero bubbles inserted in every column at the correct skewed cycles; beat_count=3; write/res_valid timing shifted by +2 only.
- Single-beat job a=7, b=all 9 -> write=00001 at c+2, 00010 at c+3, …; res_valid[0] at c+3; busy deasserts after c+7.
- rst asserted at tL+2 -> outputs reach reset values asynchronously; no further write or res_valid pulses; the next job starts cleanly.
- 300 beats with CW=8 -> beat_count saturates at 255; drain timing is still correct.

Source files
------------

// File: rtl/systolic_row_feeder_if.sv
// Operand-beat stream into the systolic row feeder.
// Each beat carries one A value plus M B values, packed column 0 in the low bits.
interface systolic_row_feeder_if #(
    parameter int N = 32,
    parameter int M = 5
);
    logic           in_valid;
    logic           in_ready;
    logic           in_last;
    logic [N-1:0]   in_a;
    logic [M*N-1:0] in_b;

    modport master (output in_valid, in_last, in_a, in_b, input in_ready);
    modport slave  (input in_valid, in_last, in_a, in_b, output in_ready);
endinterface

// File: rtl/systolic_row_feeder.sv
// Upstream driver for one systolic PE row: skews B per column to match A's ripple,
// and sequences clear / MAC / staggered unload for every PE in the row.
module systolic_row_feeder #(
    parameter int N  = 32,
    parameter int M  = 5,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_row_feeder_if.slave up,
    output logic [N-1:0]         a_out,
    output logic [M*N-1:0]       b_out,
    output logic [M-1:0]         clr,
    output logic [M-1:0]         read,
    output logic [M-1:0]         write,
    output logic [M-1:0]         res_valid,
    output logic                 busy,
    output logic [CW-1:0]        beat_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                accept;
    logic                rdy_q;
    logic                drn_start_p1;
    logic signed [N-1:0] a_p0;
    logic [M*N-1:0]      b_p0;
    logic [M-1:0]        clr_nx;

    assign up.in_ready = rdy_q;
    assign accept      = up.in_valid & rdy_q;
    assign read        = '0;

    // Stage p0: pick what enters the pipe front and the next control state.
    always_comb begin
        state_nx = state;
        clr_nx   = clr;
        a_p0     = '0;
        b_p0     = '0;
        case (state)
            IDLE: begin
                clr_nx = '1;
                if (accept) begin
                    a_p0     = up.in_a;
                    b_p0     = up.in_b;
                    clr_nx   = '0;
                    state_nx = up.in_last ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                clr_nx = '0;
                if (accept) begin
                    a_p0 = up.in_a;
                    b_p0 = up.in_b;
                    if (up.in_last) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // A column stays cleared once its unload pulse has passed, so
                // trailing bubbles cannot disturb the result sitting on Bout.
                clr_nx = clr | write;
                if (res_valid[M-1]) begin
                    state_nx = IDLE;
                    clr_nx   = '1;
                end
            end
            default: begin
                state_nx = IDLE;
                clr_nx   = '1;
            end
        endcase
    end

    // Stage p1: registered control and the unskewed A output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            clr          <= '1;
            write        <= '0;
            res_valid    <= '0;
            busy         <= 1'b0;
            rdy_q        <= 1'b1;
            drn_start_p1 <= 1'b0;
            beat_count   <= '0;
            a_out        <= '0;
        end else begin
            state        <= state_nx;
            clr          <= clr_nx;
            write        <= (write << 1) | M'(drn_start_p1);
            res_valid    <= write;
            busy         <= (state_nx != IDLE);
            rdy_q        <= (state_nx != DRAIN);
            drn_start_p1 <= (state != DRAIN) && (state_nx == DRAIN);
            a_out        <= a_p0;
            if (accept) begin
                if (state == IDLE) begin
                    beat_count <= CW'(1);
                end else if (!(&beat_count)) begin
                    beat_count <= beat_count + CW'(1);
                end
            end
        end
    end

    // Stage p1..pM: column j gets j extra register stages to match A's ripple.
    for (genvar j = 0; j < M; j++) begin : g_col
        logic signed [N-1:0] skew_p [0:j];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k <= j; k++) begin
                    skew_p[k] <= '0;
                end
            end else begin
                skew_p[0] <= b_p0[j*N +: N];
                for (int k = 1; k <= j; k++) begin
                    skew_p[k] <= skew_p[k-1];
                end
            end
        end

        assign b_out[j*N +: N] = skew_p[j];
    end

    assert property (@(posedge clk) disable iff (rst) ((write & clr) == '0));

endmodule
